mem_access_seq: RTL

MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

---
 rtl/lc3_mem_pkg.sv | 20 ++
 rtl/mem_access_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and defaults for the LC-3 memory access sequencer.
package lc3_mem_pkg;

  localparam int unsigned DATA_W          = 16;
  localparam int unsigned SRAM_AW         = 20;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam logic [DATA_W-1:0] IO_ADDR_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RD_LATCH = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR_PULSE = 3'd4,
    ST_WR_HOLD  = 3'd5,
    ST_IO_ACK   = 3'd6
  } state_t;

endpackage

// File: rtl/mem_access_seq.sv
// Sequences one SRAM read/write (or memory-mapped I/O access) per request,
// generating OE/WE strobes with a programmable wait length.
module mem_access_seq
  import lc3_mem_pkg::*;
#(
  parameter int unsigned       WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [DATA_W-1:0] IO_ADDR     = IO_ADDR_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Req_Rd,
  input  logic               Req_Wr,
  input  logic [DATA_W-1:0]  Addr,
  input  logic [DATA_W-1:0]  Wdata,
  input  logic [DATA_W-1:0]  Switches,
  input  logic [DATA_W-1:0]  Sram_Rdata,
  output logic               Busy,
  output logic               Done,
  output logic [DATA_W-1:0]  Rdata,
  output logic [SRAM_AW-1:0] Sram_Addr,
  output logic [DATA_W-1:0]  Sram_Wdata,
  output logic               Sram_Drive,
  output logic               Sram_CE_N,
  output logic               Sram_UB_N,
  output logic               Sram_LB_N,
  output logic               Sram_OE_N,
  output logic               Sram_WE_N,
  output logic [DATA_W-1:0]  Hex_Out
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_is_wr;
  logic [DATA_W-1:0]  r_rdata, r_hex, r_wdata;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic               w_accept;

  assign w_accept = Req_Wr | Req_Rd;

  // State and wait-counter register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic; the counter is loaded on entry to each strobe state
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (Addr == IO_ADDR) begin
            w_state_next = ST_IO_ACK;
          end else if (Req_Wr) begin
            w_state_next = ST_WR_SETUP;
          end else begin
            w_state_next = ST_RD_WAIT;
            w_cnt_next   = CNT_LOAD;
          end
        end
      end
      ST_RD_WAIT: begin
        if (r_cnt == '0) w_state_next = ST_RD_LATCH;
        else             w_cnt_next   = r_cnt - CNT_W'(1);
      end
      ST_RD_LATCH: w_state_next = ST_IDLE;
      ST_WR_SETUP: begin
        w_state_next = ST_WR_PULSE;
        w_cnt_next   = CNT_LOAD;
      end
      ST_WR_PULSE: begin
        if (r_cnt == '0) w_state_next = ST_WR_HOLD;
        else             w_cnt_next   = r_cnt - CNT_W'(1);
      end
      ST_WR_HOLD:  w_state_next = ST_IDLE;
      ST_IO_ACK:   w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // Strobe and handshake decode from the current state
  always_comb begin
    Busy       = (r_state != ST_IDLE);
    Done       = 1'b0;
    Sram_Drive = 1'b0;
    Sram_OE_N  = 1'b1;
    Sram_WE_N  = 1'b1;
    case (r_state)
      ST_RD_WAIT:  Sram_OE_N = 1'b0;
      ST_RD_LATCH: begin
        Sram_OE_N = 1'b0;
        Done      = 1'b1;
      end
      ST_WR_SETUP: Sram_Drive = 1'b1;
      ST_WR_PULSE: begin
        Sram_Drive = 1'b1;
        Sram_WE_N  = 1'b0;
      end
      ST_WR_HOLD: begin
        Sram_Drive = 1'b1;
        Done       = 1'b1;
      end
      ST_IO_ACK:   Done = 1'b1;
      default:     ;
    endcase
  end

  // Request capture and result registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_is_wr     <= 1'b0;
      r_sram_addr <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_hex       <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_accept) begin
        r_is_wr     <= Req_Wr;
        r_sram_addr <= SRAM_AW'(Addr);
        if (Req_Wr) r_wdata <= Wdata;
      end
      if (r_state == ST_RD_LATCH) r_rdata <= Sram_Rdata;
      if (r_state == ST_IO_ACK) begin
        if (r_is_wr) r_hex   <= r_wdata;
        else         r_rdata <= Switches;
      end
    end
  end

  assign Rdata      = r_rdata;
  assign Hex_Out    = r_hex;
  assign Sram_Addr  = r_sram_addr;
  assign Sram_Wdata = r_wdata;
  assign Sram_CE_N  = 1'b0;
  assign Sram_UB_N  = 1'b0;
  assign Sram_LB_N  = 1'b0;

endmodule
